// File: rtl/axis_slv_rx.sv
// rtl/axis_slv_rx.sv - AXI-Stream slave receiver with beat FIFO, packet byte counter and header check
module axis_slv_rx #(
  parameter int TDATA_WIDTH = 4,
  parameter int TUSER_WIDTH = 8,
  parameter int TDEST_WIDTH = 4,
  parameter int TID_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tvalid,
  output logic                     tready,
  input  logic [TDATA_WIDTH*8-1:0] tdata,
  input  logic [TDATA_WIDTH-1:0]   tstrb,
  input  logic [TDATA_WIDTH-1:0]   tkeep,
  input  logic                     tlast,
  input  logic [TID_WIDTH-1:0]     tid,
  input  logic [TDEST_WIDTH-1:0]   tdest,
  input  logic [TUSER_WIDTH-1:0]   tuser,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TDATA_WIDTH*8-1:0] rd_data,
  output logic [TDATA_WIDTH-1:0]   rd_strb,
  output logic [TDATA_WIDTH-1:0]   rd_keep,
  output logic                     rd_last,
  output logic [TID_WIDTH-1:0]     rd_id,
  output logic [TDEST_WIDTH-1:0]   rd_dest,
  output logic [TUSER_WIDTH-1:0]   rd_user,
  output logic                     pkt_done,
  output logic [15:0]              pkt_len,
  output logic                     pkt_len_ovf,
  output logic                     err_hdr,
  input  logic                     err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = TDATA_WIDTH * 8;
  localparam int EW = DW + 2 * TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [EW-1:0]          head;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   rdy_en;
  logic                   push;
  logic                   pop;
  state_t                 state_q;
  state_t                 state_d;
  logic [TID_WIDTH-1:0]   hdr_id;
  logic [TDEST_WIDTH-1:0] hdr_dest;
  logic                   hdr_mismatch;
  logic [15:0]            byte_cnt;
  logic                   cnt_ovf;
  logic [15:0]            beat_bytes;
  logic [16:0]            sum_raw;
  logic                   sum_sat;
  logic [15:0]            sum_val;

  // rdy_en holds tready low until the first edge after reset release
  assign tready   = rdy_en && (count < DEPTH_C);
  assign rd_valid = (count != '0);
  assign push     = tvalid && tready;
  assign pop      = rd_valid && rd_ready;

  // Payload reads as zero whenever the FIFO is empty, which covers reset
  assign head = rd_valid ? mem[rd_ptr] : '0;
  assign {rd_data, rd_strb, rd_keep, rd_last, rd_id, rd_dest, rd_user} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) begin
      beat_bytes = beat_bytes + 16'(tkeep[i]);
    end
    sum_raw = {1'b0, byte_cnt} + {1'b0, beat_bytes};
    sum_sat = sum_raw[16];
    sum_val = sum_sat ? 16'hFFFF : sum_raw[15:0];
  end

  always_comb begin
    state_d      = state_q;
    hdr_mismatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (push && !tlast) state_d = IN_PKT;
      end
      IN_PKT: begin
        hdr_mismatch = push && ((tid != hdr_id) || (tdest != hdr_dest));
        if (push && tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hdr_id      <= '0;
      hdr_dest    <= '0;
      byte_cnt    <= '0;
      cnt_ovf     <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_len     <= '0;
      pkt_len_ovf <= 1'b0;
      err_hdr     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_done <= 1'b0;
      if (push && state_q == IDLE) begin
        hdr_id   <= tid;
        hdr_dest <= tdest;
      end
      if (push) begin
        if (tlast) begin
          pkt_len     <= sum_val;
          pkt_len_ovf <= cnt_ovf || sum_sat;
          pkt_done    <= 1'b1;
          byte_cnt    <= '0;
          cnt_ovf     <= 1'b0;
        end else begin
          byte_cnt <= sum_val;
          cnt_ovf  <= cnt_ovf || sum_sat;
        end
      end
      // A fresh violation wins over a same-cycle clear
      if (hdr_mismatch) begin
        err_hdr <= 1'b1;
      end else if (err_clr) begin
        err_hdr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_slv_rx.sv
// tb/tb_axis_slv_rx.sv - self-checking bench for axis_slv_rx against a queue-based packet model
module tb_axis_slv_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [31:0] tdata = '0;
  logic [3:0]  tstrb = '0;
  logic [3:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic [3:0]  tid = '0;
  logic [3:0]  tdest = '0;
  logic [7:0]  tuser = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic [3:0]  rd_strb;
  logic [3:0]  rd_keep;
  logic        rd_last;
  logic [3:0]  rd_id;
  logic [3:0]  rd_dest;
  logic [7:0]  rd_user;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic        pkt_len_ovf;
  logic        err_hdr;
  logic        err_clr = 1'b0;

  axis_slv_rx #(
    .TDATA_WIDTH(4), .TUSER_WIDTH(8), .TDEST_WIDTH(4), .TID_WIDTH(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_strb(rd_strb),
    .rd_keep(rd_keep), .rd_last(rd_last), .rd_id(rd_id), .rd_dest(rd_dest), .rd_user(rd_user),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_len_ovf(pkt_len_ovf), .err_hdr(err_hdr),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [7:0]  user;
  } beat_t;

  typedef struct {
    bit          v;
    logic [3:0]  k;
    bit          l;
    logic [3:0]  id;
    logic [3:0]  dst;
    bit          rr;
    bit          clr;
    bit          e_done;
    logic [15:0] e_len;
    bit          e_err;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain queue plus unbounded byte total per packet
  beat_t       mq[$];
  bit          m_rdy_en;
  bit          m_in_pkt;
  longint      m_total;
  logic [3:0]  m_id;
  logic [3:0]  m_dest;
  logic [15:0] m_len;
  bit          m_ovf;
  bit          m_done;
  bit          m_err;
  bit          last_push;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy_en = 0; m_in_pkt = 0; m_total = 0; m_id = '0; m_dest = '0;
    m_len = '0; m_ovf = 0; m_done = 0; m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; tvalid = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_keep", rd_keep, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_len", pkt_len, 0);
    chk("rst_pkt_len_ovf", pkt_len_ovf, 0);
    chk("rst_err_hdr", err_hdr, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_release_tready", tready, 0);
    @(posedge clk);
    m_rdy_en = 1;
  endtask

  task automatic step(input bit v, input logic [3:0] k, input bit l, input logic [3:0] id,
                      input logic [3:0] dst, input bit rr, input bit clr);
    beat_t b;
    bit    push;
    bit    pop;
    bit    err_set;
    @(negedge clk);
    b.data = $urandom; b.strb = 4'($urandom); b.keep = k; b.last = l;
    b.id = id; b.dest = dst; b.user = 8'($urandom);
    tvalid = v; tdata = b.data; tstrb = b.strb; tkeep = k; tlast = l;
    tid = id; tdest = dst; tuser = b.user; rd_ready = rr; err_clr = clr;
    #1;
    chk("tready", tready, m_rdy_en && (mq.size() < DEPTH));
    chk("rd_valid", rd_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("rd_data", rd_data, mq[0].data);
      chk("rd_strb", rd_strb, mq[0].strb);
      chk("rd_keep", rd_keep, mq[0].keep);
      chk("rd_last", rd_last, mq[0].last);
      chk("rd_id", rd_id, mq[0].id);
      chk("rd_dest", rd_dest, mq[0].dest);
      chk("rd_user", rd_user, mq[0].user);
    end
    push = v && m_rdy_en && (mq.size() < DEPTH);
    pop  = rr && (mq.size() > 0);
    last_push = push;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    m_done = 0;
    err_set = 0;
    if (push) begin
      mq.push_back(b);
      if (m_in_pkt && (id != m_id || dst != m_dest)) err_set = 1;
      m_total += $countones(k);
      if (l) begin
        m_len = (m_total > 65535) ? 16'hFFFF : 16'(m_total);
        m_ovf = (m_total > 65535);
        m_done = 1;
        m_total = 0;
        m_in_pkt = 0;
      end else if (!m_in_pkt) begin
        m_in_pkt = 1; m_id = id; m_dest = dst;
      end
    end
    if (err_set) m_err = 1;
    else if (clr) m_err = 0;
    #1;
    chk("pkt_done", pkt_done, m_done);
    chk("pkt_len", pkt_len, m_len);
    chk("pkt_len_ovf", pkt_len_ovf, m_ovf);
    chk("err_hdr", err_hdr, m_err);
  endtask

  vec_t tbl[16];
  int   acc;

  initial begin
    // Hand-computed packet results: 10-byte packet, single-beat packets, header errors
    tbl[0]  = '{1, 4'hF, 0, 4'd1, 4'd2, 1, 0, 0, 16'd0,  0};
    tbl[1]  = '{1, 4'hF, 0, 4'd1, 4'd2, 1, 0, 0, 16'd0,  0};
    tbl[2]  = '{1, 4'h3, 1, 4'd1, 4'd2, 1, 0, 1, 16'd10, 0};
    tbl[3]  = '{0, 4'h0, 0, 4'd1, 4'd2, 1, 0, 0, 16'd10, 0};
    tbl[4]  = '{1, 4'h1, 1, 4'd1, 4'd2, 1, 0, 1, 16'd1,  0};
    tbl[5]  = '{1, 4'h0, 1, 4'd1, 4'd2, 1, 0, 1, 16'd0,  0};
    tbl[6]  = '{0, 4'h0, 0, 4'd1, 4'd2, 1, 0, 0, 16'd0,  0};
    tbl[7]  = '{1, 4'hF, 0, 4'd3, 4'd2, 1, 0, 0, 16'd0,  0};
    tbl[8]  = '{1, 4'hF, 1, 4'd5, 4'd2, 1, 0, 1, 16'd8,  1};
    tbl[9]  = '{0, 4'h0, 0, 4'd5, 4'd2, 1, 0, 0, 16'd8,  1};
    tbl[10] = '{0, 4'h0, 0, 4'd5, 4'd2, 1, 1, 0, 16'd8,  0};
    tbl[11] = '{0, 4'h0, 0, 4'd5, 4'd2, 1, 0, 0, 16'd8,  0};
    tbl[12] = '{1, 4'hF, 0, 4'd4, 4'd1, 1, 0, 0, 16'd8,  0};
    tbl[13] = '{1, 4'h1, 1, 4'd4, 4'd7, 1, 1, 1, 16'd5,  1};
    tbl[14] = '{0, 4'h0, 0, 4'd4, 4'd7, 1, 0, 0, 16'd5,  1};
    tbl[15] = '{0, 4'h0, 0, 4'd4, 4'd7, 1, 1, 0, 16'd5,  0};

    model_reset();
    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].k, tbl[i].l, tbl[i].id, tbl[i].dst, tbl[i].rr, tbl[i].clr);
      chk($sformatf("tbl%0d_done", i), pkt_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_len", i), pkt_len, tbl[i].e_len);
      chk($sformatf("tbl%0d_err", i), err_hdr, tbl[i].e_err);
    end

    // Backpressure: consumer stalled, master keeps offering
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 4'hF, 1, 4'd2, 4'd1, 0, 0);
      acc += int'(last_push);
    end
    chk("bp_accepted", acc, 4);
    chk("bp_tready_full", tready, 0);
    step(1, 4'hF, 1, 4'd2, 4'd1, 1, 0);
    chk("bp_full_pop_no_accept", last_push, 0);
    chk("bp_tready_after_pop", tready, 1);
    for (int i = 0; i < 5; i++) step(0, 4'h0, 0, 4'd2, 4'd1, 1, 0);
    chk("bp_drained", rd_valid, 0);

    // Reset two beats into a four-beat packet, then a clean packet
    step(1, 4'hF, 0, 4'd6, 4'd6, 0, 0);
    step(1, 4'hF, 0, 4'd6, 4'd6, 0, 0);
    do_reset();
    step(1, 4'hF, 0, 4'd6, 4'd6, 1, 0);
    step(1, 4'hF, 0, 4'd6, 4'd6, 1, 0);
    step(1, 4'hF, 0, 4'd6, 4'd6, 1, 0);
    step(1, 4'h7, 1, 4'd6, 4'd6, 1, 0);
    chk("post_reset_len", pkt_len, 15);
    chk("post_reset_done", pkt_done, 1);

    // Length saturation over a very long packet
    for (int i = 0; i < 16400; i++) begin
      step(1, 4'hF, (i == 16399), 4'd1, 4'd1, 1, 0);
    end
    chk("sat_len", pkt_len, 16'hFFFF);
    chk("sat_ovf", pkt_len_ovf, 1);
    step(1, 4'h3, 1, 4'd1, 4'd1, 1, 0);
    chk("after_sat_len", pkt_len, 2);
    chk("after_sat_ovf", pkt_len_ovf, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0,
           ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd2,
           ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'd9,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
